// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_ctrl_pkg
// Brief   : Shared FSM states and frame constants for the 24-bit UART readout.
// Rev     : 1.0  initial release
// ============================================================================
package uart_ctrl_pkg;

   localparam int BYTES_PER_FRAME = 3;
   localparam int FRAME_BITS      = 24;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      RD_WAIT = 4'd1,
      LATCH   = 4'd2,
      SEND    = 4'd3,
      BUSY_HI = 4'd4,
      BUSY_LO = 4'd5,
      GAP     = 4'd6,
      DONE    = 4'd7,
      FINISH  = 4'd8
   } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_24_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_24_ctrl
// Brief   : Reads QPSK BRAM word pairs and streams them as 3-byte UART frames.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_24_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int FRAME_NUM = 10000,
   parameter int RD_LAT    = 2,
   parameter int GAP_CYC   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        qpsk_signal_wr_over,
   input  logic [11:0] ram_rd_data_a,
   input  logic [11:0] ram_rd_data_b,
   input  logic        uart_tx_busy,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_en,
   output logic        uart_tx_start,
   output logic        uart_tx_24_done,
   output logic        uart_tx_all_done
);

   localparam int CNT_W    = $clog2(FRAME_NUM + 1);
   localparam int WAIT_MAX = (RD_LAT > GAP_CYC) ? RD_LAT : GAP_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 2);

   localparam logic [WAIT_W-1:0] RD_LAST    = WAIT_W'(RD_LAT);
   localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_NUM - 1);
   localparam logic [1:0]        BYTE_LAST  = 2'(BYTES_PER_FRAME - 1);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      frame_cnt;
   logic [1:0]            byte_idx;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [FRAME_BITS-1:0] frame_reg;
   logic [7:0]            byte_sel;
   logic                  en_nxt;
   logic                  last_frame;

   assign last_frame = (frame_cnt == FRAME_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (qpsk_signal_wr_over && !uart_tx_all_done) state_nxt = RD_WAIT;
         RD_WAIT: if (wait_cnt == RD_LAST) state_nxt = LATCH;
         LATCH:   state_nxt = SEND;
         SEND:    if (!uart_tx_busy) state_nxt = BUSY_HI;
         BUSY_HI: if (uart_tx_busy) state_nxt = BUSY_LO;
         BUSY_LO: if (!uart_tx_busy) state_nxt = (byte_idx == BYTE_LAST) ? GAP : SEND;
         GAP:     if (wait_cnt == GAP_LAST) state_nxt = DONE;
         DONE:    state_nxt = last_frame ? FINISH : RD_WAIT;
         FINISH:  state_nxt = FINISH;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_sel = frame_reg[7:0];
      case (byte_idx)
         2'd0:    byte_sel = frame_reg[23:16];
         2'd1:    byte_sel = frame_reg[15:8];
         default: byte_sel = frame_reg[7:0];
      endcase
      en_nxt          = (state == SEND) && !uart_tx_busy;
      uart_tx_24_done = (state == DONE);
   end

   // Request and data are registered together so the byte is stable for the whole en cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt        <= '0;
         byte_idx         <= '0;
         wait_cnt         <= '0;
         frame_reg        <= '0;
         uart_tx_data     <= '0;
         uart_tx_en       <= 1'b0;
         uart_tx_start    <= 1'b0;
         uart_tx_all_done <= 1'b0;
      end else begin
         uart_tx_en <= en_nxt;
         if (en_nxt) begin
            uart_tx_data <= byte_sel;
         end
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (state == RD_WAIT || state == GAP) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == LATCH) begin
            frame_reg <= {ram_rd_data_a, ram_rd_data_b};
            byte_idx  <= '0;
         end
         if (state == BUSY_LO && state_nxt == SEND) begin
            byte_idx <= byte_idx + 2'd1;
         end
         if (state == IDLE && state_nxt == RD_WAIT) begin
            uart_tx_start <= 1'b1;
         end
         // Start drops on the edge after the final done so upstream sees start & done together.
         if (state == DONE) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (last_frame) begin
               uart_tx_start    <= 1'b0;
               uart_tx_all_done <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_24_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_24_ctrl
// Brief   : Randomized bench with BRAM and UART models and a byte-stream scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_24_ctrl;

   localparam int FRAMES  = 4;
   localparam int LAT     = 2;
   localparam int GAP     = 5;
   localparam int BUDGET  = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        qpsk_signal_wr_over = 1'b0;
   logic [11:0] ram_rd_data_a;
   logic [11:0] ram_rd_data_b;
   logic        uart_tx_busy;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_en;
   logic        uart_tx_start;
   logic        uart_tx_24_done;
   logic        uart_tx_all_done;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_24_ctrl #(.FRAME_NUM(FRAMES), .RD_LAT(LAT), .GAP_CYC(GAP)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .qpsk_signal_wr_over (qpsk_signal_wr_over),
      .ram_rd_data_a       (ram_rd_data_a),
      .ram_rd_data_b       (ram_rd_data_b),
      .uart_tx_busy        (uart_tx_busy),
      .uart_tx_data        (uart_tx_data),
      .uart_tx_en          (uart_tx_en),
      .uart_tx_start       (uart_tx_start),
      .uart_tx_24_done     (uart_tx_24_done),
      .uart_tx_all_done    (uart_tx_all_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // BRAM model: address steps by 2 on start & done, data delayed by LAT cycles.
   logic [11:0] mem [0:19];
   logic [4:0]  addr;
   logic [11:0] pa1, pa2, pb1, pb2;
   assign ram_rd_data_a = pa2;
   assign ram_rd_data_b = pb2;

   always @(posedge clk) begin
      if (rst) addr <= '0;
      else if (uart_tx_start && uart_tx_24_done) addr <= addr + 5'd2;
      pa1 <= mem[addr];
      pb1 <= mem[addr + 5'd1];
      pa2 <= pa1;
      pb2 <= pb1;
   end

   // UART model: busy for a random number of cycles after each request.
   int   busy_cnt;
   logic force_busy = 1'b0;
   assign uart_tx_busy = (busy_cnt != 0) || force_busy;

   always @(posedge clk) begin
      if (rst) busy_cnt <= 0;
      else if (uart_tx_en && busy_cnt == 0) busy_cnt <= $urandom_range(12, 2);
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   // Scoreboard / protocol monitor.
   logic [7:0] exp_q [$];
   logic [7:0] got_bytes [0:11];
   int   en_cnt   = 0;
   int   done_cnt = 0;
   int   cyc      = 0;
   int   fall_cyc = 0;
   logic busy_d   = 1'b0;
   logic en_d     = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (uart_tx_en) begin
            check("en_one_cycle", {31'd0, en_d}, 32'd0);
            check("en_while_busy", {31'd0, uart_tx_busy}, 32'd0);
            if (exp_q.size() == 0) check("extra_en", en_cnt, FRAMES * 3);
            else check("byte", {24'd0, uart_tx_data}, {24'd0, exp_q.pop_front()});
            if (en_cnt < 12) got_bytes[en_cnt] = uart_tx_data;
            en_cnt++;
         end
         if (uart_tx_24_done) begin
            check("start_at_done", {31'd0, uart_tx_start}, 32'd1);
            check("gap_cycles", cyc - fall_cyc, GAP + 1);
            check("done_bytes", en_cnt, (done_cnt + 1) * 3);
            done_cnt++;
         end
         if (busy_d && !uart_tx_busy) fall_cyc = cyc;
      end
      busy_d = uart_tx_busy;
      en_d   = uart_tx_en && !rst;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load_mem(input logic first_fixed);
      logic [11:0] a, b;
      for (int i = 0; i < 20; i++) mem[i] = 12'($urandom_range(4095, 0));
      if (first_fixed) begin
         mem[0] = 12'hABC;
         mem[1] = 12'h123;
      end
      exp_q.delete();
      for (int k = 0; k < FRAMES; k++) begin
         a = mem[2*k];
         b = mem[2*k+1];
         exp_q.push_back(a[11:4]);
         exp_q.push_back({a[3:0], b[11:8]});
         exp_q.push_back(b[7:0]);
      end
      en_cnt   = 0;
      done_cnt = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"},  {24'd0, uart_tx_data}, 32'd0);
      check({tag, "_en"},    {31'd0, uart_tx_en}, 32'd0);
      check({tag, "_start"}, {31'd0, uart_tx_start}, 32'd0);
      check({tag, "_done"},  {31'd0, uart_tx_24_done}, 32'd0);
      check({tag, "_all"},   {31'd0, uart_tx_all_done}, 32'd0);
   endtask

   task automatic wait_all_done();
      for (int i = 0; i < BUDGET && !uart_tx_all_done; i++) tick();
      check("all_done_reached", {31'd0, uart_tx_all_done}, 32'd1);
   endtask

   initial begin
      int   started;
      logic [7:0] fixed_exp [0:2];
      fixed_exp[0] = 8'hAB;
      fixed_exp[1] = 8'hC1;
      fixed_exp[2] = 8'h23;

      // Reset and idle with wr_over low.
      load_mem(1'b1);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_outputs_zero("reset");
      started = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (uart_tx_start) started++;
      end
      check("idle_start_cycles", started, 0);
      check("idle_en_count", en_cnt, 0);
      check("idle_done_count", done_cnt, 0);

      // Full readout; busy forced high at frame 2 SEND entry; wr_over dropped mid-readout.
      qpsk_signal_wr_over = 1'b1;
      tick();
      check("start_after_wr_over", {31'd0, uart_tx_start}, 32'd1);
      for (int i = 0; i < BUDGET && done_cnt < 1; i++) tick();
      check("first_done_seen", done_cnt, 1);
      for (int i = 0; i < 3; i++) check("fixed_byte", {24'd0, got_bytes[i]}, {24'd0, fixed_exp[i]});
      force_busy = 1'b1;
      repeat (30) tick();
      check("en_withheld", en_cnt, 3);
      force_busy = 1'b0;
      for (int i = 0; i < BUDGET && done_cnt < 2; i++) tick();
      qpsk_signal_wr_over = 1'b0;
      wait_all_done();
      check("run1_done_count", done_cnt, FRAMES);
      check("run1_en_count", en_cnt, FRAMES * 3);
      check("run1_start_low", {31'd0, uart_tx_start}, 32'd0);
      qpsk_signal_wr_over = 1'b1;
      repeat (100) tick();
      check("finish_en_count", en_cnt, FRAMES * 3);
      check("finish_done_count", done_cnt, FRAMES);
      check("finish_all_done", {31'd0, uart_tx_all_done}, 32'd1);
      check("finish_queue_empty", exp_q.size(), 0);

      // Restart, then reset during byte 1 of frame 2.
      rst = 1'b1;
      tick();
      load_mem(1'b0);
      rst = 1'b0;
      for (int i = 0; i < BUDGET && en_cnt < 5; i++) tick();
      check("reached_frame2_byte1", en_cnt, 5);
      rst = 1'b1;
      tick();
      check_outputs_zero("midrst");
      load_mem(1'b0);
      tick();
      rst = 1'b0;
      tick();
      check("restart_start", {31'd0, uart_tx_start}, 32'd1);
      wait_all_done();
      check("run2_done_count", done_cnt, FRAMES);
      check("run2_en_count", en_cnt, FRAMES * 3);
      check("run2_queue_empty", exp_q.size(), 0);
      check("run2_start_low", {31'd0, uart_tx_start}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
